// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
// Shift-add multiply and restoring divide, one step per cycle, sign fix-up in a final state.
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [WIDTH-1:0] CNT_INIT = (WIDTH)'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             dz_reg;
  logic [WIDTH-1:0] acc_reg, q_reg, m_reg, count_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg;

  logic rtype, is_mult, is_div, md_op, hl_op, accept, sgn, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign rtype   = en && (ALUOp == 4'b1111);
  assign is_mult = rtype && (func == F_MULT || func == F_MULTU);
  assign is_div  = rtype && (func == F_DIV || func == F_DIVU);
  assign md_op   = is_mult || is_div;
  assign hl_op   = rtype && (func == F_MFHI || func == F_MTHI || func == F_MFLO || func == F_MTLO);
  assign busy    = (state_reg != S_IDLE);
  assign stall   = busy && (md_op || hl_op);
  assign accept  = md_op && !busy;
  // MULT and DIV are the signed forms: funct bit 0 clear
  assign sgn     = !func[0];
  assign b_zero  = (b == '0);
  assign abs_a   = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b   = (sgn && b[WIDTH-1]) ? -b : b;

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = dz_reg;
  assign mf_data  = (rtype && func == F_MFHI) ? hi_reg :
                    (rtype && func == F_MFLO) ? lo_reg : '0;

  // One iteration step: acc holds product-high / partial remainder, q holds multiplier / quotient
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   acc_step, q_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   hi_fin, lo_fin;

  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
    div_shift = {acc_reg, q_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    acc_step  = mul_sum[WIDTH:1];
    q_step    = {mul_sum[0], q_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (!div_diff[WIDTH]) begin
        acc_step = div_diff[WIDTH-1:0];
        q_step   = {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_shift[WIDTH-1:0];
        q_step   = {q_reg[WIDTH-2:0], 1'b0};
      end
    end
    prod     = {acc_reg, q_reg};
    prod_fix = neg_q_reg ? -prod : prod;
    hi_fin   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fin   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      hi_fin = neg_r_reg ? -acc_reg : acc_reg;
      lo_fin = neg_q_reg ? -q_reg : q_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept && !(is_div && b_zero)) state_next = S_CALC;
      S_CALC: if (count_reg == '0) state_next = S_SIGN;
      S_SIGN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      dz_reg     <= 1'b0;
      acc_reg    <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      count_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            dz_reg     <= 1'b0;
            is_div_reg <= is_div;
            neg_q_reg  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_reg  <= sgn && a[WIDTH-1];
            count_reg  <= CNT_INIT;
            acc_reg    <= '0;
            if (is_div && b_zero) begin
              lo_reg <= '1;
              hi_reg <= a;
              dz_reg <= 1'b1;
            end else if (is_div) begin
              q_reg <= abs_a;
              m_reg <= abs_b;
            end else begin
              q_reg <= abs_b;
              m_reg <= abs_a;
            end
          end else if (rtype && func == F_MTHI) begin
            hi_reg <= a;
          end else if (rtype && func == F_MTLO) begin
            lo_reg <= a;
          end
        end
        S_CALC: begin
          acc_reg <= acc_step;
          q_reg   <= q_step;
          if (count_reg != '0) count_reg <= count_reg - 1'b1;
        end
        S_SIGN: begin
          hi_reg <= hi_fin;
          lo_reg <= lo_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
// Randomized self-checking bench for ula_muldiv at WIDTH=32 and WIDTH=8.
// Expected HI/LO come from plain integer arithmetic on the operands.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, en, sel;
  logic [3:0]  aluop;
  logic [5:0]  func;
  logic [31:0] a, b;

  logic        busy32, stall32, dz32, busy8, stall8, dz8;
  logic [31:0] mf32, hi32, lo32;
  logic [7:0]  mf8, hi8, lo8;
  logic        en32, en8;

  logic        busy_m, stall_m, dz_m;
  logic [31:0] hi_m, lo_m, mf_m;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_hi [2];
  logic [31:0] exp_lo [2];
  logic        exp_dz [2];

  always #5 clk = ~clk;

  assign en32    = en & ~sel;
  assign en8     = en & sel;
  assign busy_m  = sel ? busy8 : busy32;
  assign stall_m = sel ? stall8 : stall32;
  assign dz_m    = sel ? dz8 : dz32;
  assign hi_m    = sel ? {24'h0, hi8} : hi32;
  assign lo_m    = sel ? {24'h0, lo8} : lo32;
  assign mf_m    = sel ? {24'h0, mf8} : mf32;

  ula_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en32), .ALUOp(aluop), .func(func), .a(a), .b(b),
    .busy(busy32), .stall(stall32), .mf_data(mf32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  ula_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .ALUOp(aluop), .func(func), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .stall(stall8), .mf_data(mf8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // Reference: signed/unsigned arithmetic on w-bit operands held in 64-bit integers
  task automatic ref_md(input int w, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    logic [63:0] mask, ux, uy, p;
    longint sx, sy, qq, rr;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'h0, x} & mask;
    uy = {32'h0, y} & mask;
    sx = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    rdz = 1'b0;
    p = 64'h0;
    if (f == 6'b011000) p = sx * sy;
    else if (f == 6'b011001) p = ux * uy;
    if (f[1]) begin
      if (uy == 0) begin
        p = (ux << w) | mask;
        rdz = 1'b1;
      end else if (f[0]) begin
        p = ((ux % uy) << w) | ((ux / uy) & mask);
      end else begin
        qq = sx / sy;
        rr = sx % sy;
        p = ((rr & mask) << w) | (qq & mask);
      end
    end
    rhi = 32'((p >> w) & mask);
    rlo = 32'(p & mask);
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int cyc = 0;
    int w = sel ? 8 : 32;
    logic [31:0] rh, rl;
    logic rd;
    ref_md(w, f, x, y, rh, rl, rd);
    exp_hi[sel] = rh; exp_lo[sel] = rl; exp_dz[sel] = rd;
    @(negedge clk);
    en = 1'b1; aluop = 4'b1111; func = f; a = x; b = y;
    @(posedge clk); #1;
    en = 1'b0; func = 6'h0;
    while (busy_m && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    $display("%s w=%0d f=%b a=%h b=%h -> hi=%h lo=%h dz=%0d busy_cycles=%0d",
             tag, w, f, x, y, hi_m, lo_m, dz_m, cyc);
    check({tag, "_busy_cycles"}, 64'(cyc), rd ? 64'd0 : 64'(w + 1));
    check({tag, "_hi"}, {32'h0, hi_m}, {32'h0, rh});
    check({tag, "_lo"}, {32'h0, lo_m}, {32'h0, rl});
    check({tag, "_dz"}, {63'h0, dz_m}, {63'h0, rd});
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] x, y, rh, rl;
    logic        rd;
    int          cyc;

    rst_n = 1'b0; en = 1'b0; sel = 1'b0; aluop = 4'h0; func = 6'h0; a = '0; b = '0;
    exp_hi[0] = '0; exp_lo[0] = '0; exp_dz[0] = 1'b0;
    exp_hi[1] = '0; exp_lo[1] = '0; exp_dz[1] = 1'b0;
    #12;
    check("reset_busy", {63'h0, busy32}, 64'h0);
    check("reset_hi", {32'h0, hi32}, 64'h0);
    check("reset_lo", {32'h0, lo32}, 64'h0);
    check("reset_dz", {63'h0, dz32}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    run_md("mult_7_m3", 6'b011000, 32'd7, 32'hFFFFFFFD);
    run_md("divu_100_7", 6'b011011, 32'd100, 32'd7);
    run_md("div_m7_2", 6'b011010, 32'hFFFFFFF9, 32'd2);
    run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    run_md("divu_by0", 6'b011011, 32'd5, 32'd0);

    // MTHI while idle
    @(negedge clk); en = 1'b1; aluop = 4'b1111; func = 6'b010001; a = 32'h1234;
    @(posedge clk); #1; en = 1'b0; func = 6'h0;
    $display("mthi a=1234 -> hi=%h", hi32);
    check("mthi_hi", {32'h0, hi32}, 64'h1234);

    // MULTU then MFLO held back-to-back
    @(negedge clk); en = 1'b1; aluop = 4'b1111; func = 6'b011001; a = '1; b = '1;
    @(posedge clk); #1; func = 6'b010010; a = '0; #1;
    cyc = 0;
    while (stall32 && cyc < 200) begin
      cyc++;
      @(posedge clk); #2;
    end
    $display("multu ff*ff + mflo: stall_cycles=%0d mf_data=%h hi=%h", cyc, mf32, hi32);
    check("mflo_stall_cycles", 64'(cyc), 64'd33);
    check("mflo_data", {32'h0, mf32}, 64'h1);
    check("mflo_hi", {32'h0, hi32}, 64'hFFFFFFFE);
    en = 1'b0; func = 6'h0;

    // MTLO issued while busy: stalls, then overwrites the new LO
    ref_md(32, 6'b011000, 32'h00012345, 32'hFFF00007, rh, rl, rd);
    @(negedge clk); en = 1'b1; aluop = 4'b1111; func = 6'b011000; a = 32'h00012345; b = 32'hFFF00007;
    @(posedge clk); #1; func = 6'b010011; a = 32'hCAFEF00D; #1;
    cyc = 0;
    while (stall32 && cyc < 200) begin
      cyc++;
      @(posedge clk); #2;
    end
    @(posedge clk); #1; en = 1'b0; func = 6'h0;
    $display("mult + mtlo under stall: stall_cycles=%0d hi=%h lo=%h", cyc, hi32, lo32);
    check("mtlo_stall_cycles", 64'(cyc), 64'd33);
    check("mtlo_hi", {32'h0, hi32}, {32'h0, rh});
    check("mtlo_lo", {32'h0, lo32}, 64'hCAFEF00D);

    for (int i = 0; i < 12; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      run_md("rand32", f, x, y);
    end

    // async reset mid-CALC of a MULT
    @(negedge clk); en = 1'b1; aluop = 4'b1111; func = 6'b011000; a = 32'd7; b = 32'hFFFFFFFD;
    @(posedge clk); #1; en = 1'b0; func = 6'h0;
    repeat (9) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    $display("async reset mid-calc -> busy=%0d hi=%h lo=%h dz=%0d", busy32, hi32, lo32, dz32);
    check("arst_busy", {63'h0, busy32}, 64'h0);
    check("arst_hi", {32'h0, hi32}, 64'h0);
    check("arst_lo", {32'h0, lo32}, 64'h0);
    check("arst_dz", {63'h0, dz32}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    run_md("divu_9_3", 6'b011011, 32'd9, 32'd3);

    sel = 1'b1;
    run_md("w8_mult_7f_80", 6'b011000, 32'h7F, 32'h80);
    run_md("w8_div_ovf", 6'b011010, 32'h80, 32'hFF);
    run_md("w8_div_by0", 6'b011010, 32'hA5, 32'h00);
    for (int i = 0; i < 10; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      run_md("rand8", f, x, y);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
